ex_data_loader: RTL and testbench

- Host-side loader directly upstream of the accelerator top's external write port (ex_data/ex_addr/ex_we).
- Watches the controller's seven load-request lines: conv_weight1..3, fc_weight1..2, img_input, right_answer.
- For the single active request, accepts exactly that region's word count from a host valid/ready stream and writes it at addresses 0..N-1.
- Then pulses the matching done_* line back to the controller.

---
 rtl/ld_pkg.sv | 40 ++++
 rtl/ld_req_arbiter.sv | 35 +++
 rtl/ex_data_loader.sv | 181 ++++++++++++++++++
 tb/tb_ex_data_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
// ld_pkg: shared definitions for the host-side data loader.
//   - network geometry and the per-region word counts derived from it
//   - region codes (one per controller load request, also the priority order)
//   - loader FSM state encoding
package ld_pkg;

   localparam int unsigned FRT_CELL = 32;
   localparam int unsigned MID_CELL = 20;
   localparam int unsigned BCK_CELL = 10;
   localparam int unsigned IMG_SIZE = 18;
   localparam int unsigned CONV_K   = 3;

   localparam int unsigned CONV_WORDS_DEF = CONV_K * CONV_K;
   localparam int unsigned FCW1_WORDS_DEF = FRT_CELL * MID_CELL;
   localparam int unsigned FCW2_WORDS_DEF = MID_CELL * BCK_CELL;
   localparam int unsigned IMG_WORDS_DEF  = IMG_SIZE * IMG_SIZE;
   localparam int unsigned ANS_WORDS_DEF  = BCK_CELL;

   localparam int unsigned NUM_REQ = 7;

   // Code value doubles as the bit index in the request / done vectors
   // and as priority rank (lower code wins).
   typedef enum logic [2:0] {
      REG_CW1  = 3'd0,
      REG_CW2  = 3'd1,
      REG_CW3  = 3'd2,
      REG_FCW1 = 3'd3,
      REG_FCW2 = 3'd4,
      REG_IMG  = 3'd5,
      REG_ANS  = 3'd6
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_DONE      = 2'd2,
      ST_WAIT_DROP = 2'd3
   } ld_state_e;

endpackage

// File: rtl/ld_req_arbiter.sv
// ld_req_arbiter: combinational fixed-priority encoder for the load requests.
// Ports:
//   req    in  [NUM_REQ]  request vector, bit index = region code
//   region out region_e   highest-priority active region (lowest index)
//   valid  out 1          any request active
//   multi  out 1          more than one request active
module ld_req_arbiter
   import ld_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   output region_e            region,
   output logic               valid,
   output logic               multi
);

   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   logic found;

   always_comb begin
      region = REG_CW1;
      found  = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !found) begin
            region = region_e'(i[2:0]);
            found  = 1'b1;
         end
      end
   end

   assign valid = |req;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi = (req & (req - ONE)) != '0;

endmodule

// File: rtl/ex_data_loader.sv
// ex_data_loader: host-side loader feeding the accelerator's external write port.
// On a controller load request it accepts that region's word count from a host
// valid/ready stream, writes words at addresses 0..N-1, then pulses done_*.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   s_data/s_valid/s_ready  host word stream (s_ready from registered state only)
//   conv_weight1..right_answer  load requests from the controller
//   ex_data/ex_addr/ex_we   registered write port to the accelerator top
//   done_*                  one-cycle region-complete pulses
//   busy                    FSM not idle
//   err_multi_req           sticky: several requests seen together while idle
module ex_data_loader
   import ld_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned CW1_WORDS  = CONV_WORDS_DEF,
   parameter int unsigned CW2_WORDS  = CONV_WORDS_DEF,
   parameter int unsigned CW3_WORDS  = CONV_WORDS_DEF,
   parameter int unsigned FCW1_WORDS = FCW1_WORDS_DEF,
   parameter int unsigned FCW2_WORDS = FCW2_WORDS_DEF,
   parameter int unsigned IMG_WORDS  = IMG_WORDS_DEF,
   parameter int unsigned ANS_WORDS  = ANS_WORDS_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic              conv_weight1,
   input  logic              conv_weight2,
   input  logic              conv_weight3,
   input  logic              fc_weight1,
   input  logic              fc_weight2,
   input  logic              img_input,
   input  logic              right_answer,
   output logic [DATA_W-1:0] ex_data,
   output logic [ADDR_W-1:0] ex_addr,
   output logic              ex_we,
   output logic              done_conv_weight1,
   output logic              done_conv_weight2,
   output logic              done_conv_weight3,
   output logic              done_fc_weight1,
   output logic              done_fc_weight2,
   output logic              done_img_input,
   output logic              done_right_answer,
   output logic              busy,
   output logic              err_multi_req
);

   // One extra bit so a full 2^ADDR_W region size is representable.
   localparam int unsigned SZ_W = ADDR_W + 1;

   logic [NUM_REQ-1:0] req;
   region_e            arb_region;
   logic               arb_valid;
   logic               arb_multi;

   ld_state_e          state_q,   state_d;
   region_e            region_q,  region_d;
   logic [ADDR_W-1:0]  cnt_q,     cnt_d;
   logic [SZ_W-1:0]    size_q,    size_d;
   logic               ex_we_q,   ex_we_d;
   logic [DATA_W-1:0]  ex_data_q, ex_data_d;
   logic [ADDR_W-1:0]  ex_addr_q, ex_addr_d;
   logic [NUM_REQ-1:0] done_q,    done_d;
   logic               err_q,     err_d;

   logic accept;
   logic req_held;
   logic last_word;

   assign req = {right_answer, img_input, fc_weight2, fc_weight1,
                 conv_weight3, conv_weight2, conv_weight1};

   ld_req_arbiter u_arb (
      .req    (req),
      .region (arb_region),
      .valid  (arb_valid),
      .multi  (arb_multi)
   );

   function automatic logic [SZ_W-1:0] region_words(input region_e r);
      case (r)
         REG_CW1:  return SZ_W'(CW1_WORDS);
         REG_CW2:  return SZ_W'(CW2_WORDS);
         REG_CW3:  return SZ_W'(CW3_WORDS);
         REG_FCW1: return SZ_W'(FCW1_WORDS);
         REG_FCW2: return SZ_W'(FCW2_WORDS);
         REG_IMG:  return SZ_W'(IMG_WORDS);
         default:  return SZ_W'(ANS_WORDS);
      endcase
   endfunction

   assign s_ready   = (state_q == ST_LOAD) && ({1'b0, cnt_q} < size_q);
   assign accept    = s_valid && s_ready;
   assign req_held  = req[region_q];
   assign last_word = ({1'b0, cnt_q} == (size_q - SZ_W'(1)));

   always_comb begin
      state_d   = state_q;
      region_d  = region_q;
      cnt_d     = cnt_q;
      size_d    = size_q;
      ex_we_d   = 1'b0;
      ex_data_d = ex_data_q;
      ex_addr_d = ex_addr_q;
      done_d    = '0;
      err_d     = err_q;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               region_d = arb_region;
               cnt_d    = '0;
               size_d   = region_words(arb_region);
               state_d  = ST_LOAD;
               if (arb_multi) err_d = 1'b1;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               ex_we_d   = 1'b1;
               ex_data_d = s_data;
               ex_addr_d = cnt_q;
               cnt_d     = cnt_q + ADDR_W'(1);
            end
            // A dropped request aborts even on the final word: the write
            // still lands, but the region is not reported complete.
            if (!req_held)                 state_d = ST_IDLE;
            else if (accept && last_word)  state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = NUM_REQ'(1) << region_q;
            state_d = ST_WAIT_DROP;
         end
         ST_WAIT_DROP: begin
            if (!req_held) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         region_q  <= REG_CW1;
         cnt_q     <= '0;
         size_q    <= '0;
         ex_we_q   <= 1'b0;
         ex_data_q <= '0;
         ex_addr_q <= '0;
         done_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         region_q  <= region_d;
         cnt_q     <= cnt_d;
         size_q    <= size_d;
         ex_we_q   <= ex_we_d;
         ex_data_q <= ex_data_d;
         ex_addr_q <= ex_addr_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ex_we             = ex_we_q;
   assign ex_data           = ex_data_q;
   assign ex_addr           = ex_addr_q;
   assign done_conv_weight1 = done_q[REG_CW1];
   assign done_conv_weight2 = done_q[REG_CW2];
   assign done_conv_weight3 = done_q[REG_CW3];
   assign done_fc_weight1   = done_q[REG_FCW1];
   assign done_fc_weight2   = done_q[REG_FCW2];
   assign done_img_input    = done_q[REG_IMG];
   assign done_right_answer = done_q[REG_ANS];
   assign busy              = (state_q != ST_IDLE);
   assign err_multi_req     = err_q;

endmodule

// File: tb/tb_ex_data_loader.sv
// tb_ex_data_loader: directed self-checking bench for ex_data_loader.
module tb_ex_data_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        conv_weight1, conv_weight2, conv_weight3;
   logic        fc_weight1, fc_weight2, img_input, right_answer;
   logic [15:0] ex_data;
   logic [15:0] ex_addr;
   logic        ex_we;
   logic        done_conv_weight1, done_conv_weight2, done_conv_weight3;
   logic        done_fc_weight1, done_fc_weight2, done_img_input, done_right_answer;
   logic        busy;
   logic        err_multi_req;
   logic [6:0]  done_vec;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int got;

   int wr_addr[$];
   int wr_data[$];
   int wr_cyc[$];
   int done_cnt[7];
   int done_cyc[7];

   always #5 clk = ~clk;

   ex_data_loader #(
      .DATA_W (16),
      .ADDR_W (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .s_data            (s_data),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .conv_weight1      (conv_weight1),
      .conv_weight2      (conv_weight2),
      .conv_weight3      (conv_weight3),
      .fc_weight1        (fc_weight1),
      .fc_weight2        (fc_weight2),
      .img_input         (img_input),
      .right_answer      (right_answer),
      .ex_data           (ex_data),
      .ex_addr           (ex_addr),
      .ex_we             (ex_we),
      .done_conv_weight1 (done_conv_weight1),
      .done_conv_weight2 (done_conv_weight2),
      .done_conv_weight3 (done_conv_weight3),
      .done_fc_weight1   (done_fc_weight1),
      .done_fc_weight2   (done_fc_weight2),
      .done_img_input    (done_img_input),
      .done_right_answer (done_right_answer),
      .busy              (busy),
      .err_multi_req     (err_multi_req)
   );

   assign done_vec = {done_right_answer, done_img_input, done_fc_weight2, done_fc_weight1,
                      done_conv_weight3, done_conv_weight2, done_conv_weight1};

   always @(posedge clk) cyc <= cyc + 1;

   // Write / done log, sampled mid-cycle.
   always @(negedge clk) begin
      if (ex_we === 1'b1) begin
         wr_addr.push_back(int'(ex_addr));
         wr_data.push_back(int'(ex_data));
         wr_cyc.push_back(cyc);
      end
      for (int j = 0; j < 7; j++) begin
         if (done_vec[j] === 1'b1) begin
            done_cnt[j]++;
            done_cyc[j] = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      for (int j = 0; j < 7; j++) begin
         done_cnt[j] = 0;
         done_cyc[j] = 0;
      end
   endtask

   // Present words base+k (k = words accepted so far) until target accepts or
   // budget cycles; toggle=1 offers valid only on even cycles.
   task automatic stream(input int target, input int budget, input bit toggle,
                         input logic [15:0] base, output int accepted);
      int k = 0;
      for (int c = 0; c < budget && k < target; c++) begin
         s_valid = toggle ? (c % 2 == 0) : 1'b1;
         s_data  = base + 16'(k);
         @(negedge clk);
         if (s_valid && s_ready) k++;
         @(posedge clk);
         #1;
      end
      s_valid   = 1'b0;
      accepted  = k;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"},    32'(ex_we), 32'h0);
      check({tag, "_data"},  32'(ex_data), 32'h0);
      check({tag, "_addr"},  32'(ex_addr), 32'h0);
      check({tag, "_ready"}, 32'(s_ready), 32'h0);
      check({tag, "_busy"},  32'(busy), 32'h0);
      check({tag, "_err"},   32'(err_multi_req), 32'h0);
      check({tag, "_done"},  32'(done_vec), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      s_data = '0; s_valid = 1'b0;
      conv_weight1 = 0; conv_weight2 = 0; conv_weight3 = 0;
      fc_weight1 = 0; fc_weight2 = 0; img_input = 0; right_answer = 0;
      tick(3);
      check_reset_outputs("reset");
      reset = 1'b0;
      tick(2);
      check("idle_busy", 32'(busy), 32'h0);

      // Answer region: continuous valid, 10 back-to-back writes.
      clear_log();
      right_answer = 1'b1;
      stream(10, 40, 1'b0, 16'h0100, got);
      check("ans_accepts", got, 10);
      check("ans_last_we", 32'(ex_we), 32'h1);
      check("ans_ready_drop", 32'(s_ready), 32'h0);
      tick(4);
      check("ans_nwr", wr_addr.size(), 10);
      for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
         check("ans_addr", wr_addr[i], i);
         check("ans_data", wr_data[i], 32'h0100 + i);
         check("ans_b2b", wr_cyc[i] - wr_cyc[0], i);
      end
      check("ans_done_cnt", done_cnt[6], 1);
      if (wr_cyc.size() == 10) check("ans_done_cyc", done_cyc[6], wr_cyc[9] + 1);
      check("ans_busy_wait", 32'(busy), 32'h1);

      // Request held long after done: no reload.
      s_valid = 1'b1;
      tick(20);
      check("hold_nwr", wr_addr.size(), 10);
      check("hold_done_cnt", done_cnt[6], 1);
      check("hold_ready", 32'(s_ready), 32'h0);
      check("hold_busy", 32'(busy), 32'h1);
      s_valid = 1'b0;
      right_answer = 1'b0;
      tick(1);
      check("hold_drop_busy", 32'(busy), 32'h0);

      // Image region with valid toggling.
      clear_log();
      img_input = 1'b1;
      stream(324, 1000, 1'b1, 16'h2000, got);
      check("img_accepts", got, 324);
      tick(4);
      check("img_nwr", wr_addr.size(), 324);
      for (int i = 0; i < 324 && i < wr_addr.size(); i++) begin
         check("img_addr", wr_addr[i], i);
         check("img_data", wr_data[i], 32'h2000 + i);
         if (i > 0) check("img_gap", wr_cyc[i] - wr_cyc[i-1], 2);
      end
      check("img_done_cnt", done_cnt[5], 1);
      img_input = 1'b0;
      tick(2);
      check("img_idle", 32'(busy), 32'h0);

      // Two simultaneous requests: cw2 wins, error flag sticks.
      check("multi_err_pre", 32'(err_multi_req), 32'h0);
      clear_log();
      conv_weight2 = 1'b1;
      fc_weight1   = 1'b1;
      stream(9, 40, 1'b0, 16'h3000, got);
      check("multi_accepts", got, 9);
      tick(4);
      check("multi_nwr", wr_addr.size(), 9);
      for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
         check("multi_addr", wr_addr[i], i);
         check("multi_data", wr_data[i], 32'h3000 + i);
      end
      check("multi_cw2_done", done_cnt[1], 1);
      check("multi_fc1_done", done_cnt[3], 0);
      check("multi_err", 32'(err_multi_req), 32'h1);
      conv_weight2 = 1'b0;
      fc_weight1   = 1'b0;
      tick(3);
      check("multi_err_sticky", 32'(err_multi_req), 32'h1);
      check("multi_idle", 32'(busy), 32'h0);
      check("multi_fc1_done2", done_cnt[3], 0);

      // fc_weight2 aborted after 50 words, then reloaded from address 0.
      clear_log();
      fc_weight2 = 1'b1;
      stream(50, 200, 1'b0, 16'h4000, got);
      check("abort_accepts", got, 50);
      fc_weight2 = 1'b0;
      check("abort_last_we", 32'(ex_we), 32'h1);
      check("abort_last_addr", 32'(ex_addr), 32'd49);
      tick(1);
      check("abort_busy", 32'(busy), 32'h0);
      tick(5);
      check("abort_nwr", wr_addr.size(), 50);
      check("abort_done", done_cnt[4], 0);
      clear_log();
      fc_weight2 = 1'b1;
      stream(200, 400, 1'b0, 16'h5000, got);
      check("reload_accepts", got, 200);
      tick(4);
      check("reload_nwr", wr_addr.size(), 200);
      if (wr_addr.size() == 200) begin
         check("reload_addr0", wr_addr[0], 0);
         check("reload_data0", wr_data[0], 32'h5000);
         check("reload_addr199", wr_addr[199], 199);
         check("reload_data199", wr_data[199], 32'h5000 + 199);
      end
      check("reload_done", done_cnt[4], 1);
      fc_weight2 = 1'b0;
      tick(2);

      // Reset while conv_weight1 word 5 is being offered.
      clear_log();
      conv_weight1 = 1'b1;
      stream(5, 40, 1'b0, 16'h6000, got);
      check("rst_accepts", got, 5);
      s_valid = 1'b1;
      s_data  = 16'h6005;
      reset   = 1'b1;
      tick(1);
      check_reset_outputs("midrst");
      reset        = 1'b0;
      s_valid      = 1'b0;
      conv_weight1 = 1'b0;
      tick(2);
      check("midrst_done", done_cnt[0], 0);
      clear_log();
      conv_weight1 = 1'b1;
      stream(9, 40, 1'b0, 16'h7000, got);
      check("fresh_accepts", got, 9);
      tick(4);
      check("fresh_nwr", wr_addr.size(), 9);
      for (int i = 0; i < 9 && i < wr_addr.size(); i++) begin
         check("fresh_addr", wr_addr[i], i);
         check("fresh_data", wr_data[i], 32'h7000 + i);
      end
      check("fresh_done", done_cnt[0], 1);
      conv_weight1 = 1'b0;
      tick(2);
      check("final_idle", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
